apb_timer_if: RTL and testbench

//  APB slave front-end for the 64-bit timer. Decodes APB transfers into the

---
 rtl/apb_timer_if.sv | 160 ++++++++++++++++
 tb/tb_apb_timer_if.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_if.sv
// APB slave front-end for the 64-bit timer: TCR register, wait states, counter write port.
// Define APB_SNAPSHOT_EN to make a TDR0-then-TDR1 read return a coherent 64-bit value.
module apb_timer_if #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] TCR_DEFAULT = 32'h0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [1:0]        wr_sel,
    output logic [31:0]       wdt,
    output logic [3:0]        wr_strb,
    output logic              timer_en,
    output logic [3:0]        div_val,
    input  logic [63:0]       cnt
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            r_state, w_state_d;
    logic [2:0]        r_wait_cnt, w_wait_cnt_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic [31:0]       r_tcr, w_tcr_d;
    logic              w_start, w_done, w_err;
    logic              w_sel_tcr, w_sel_tdr0, w_sel_tdr1;
    logic [31:0]       w_tdr1_rd;

    assign w_start = psel & ~penable;

    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) w_state_d = StSetup;
            end
            StSetup: begin
                w_wait_cnt_d = '0;
                w_state_d    = psel ? StAccess : StIdle;
            end
            StAccess: begin
                if (!psel) begin
                    w_state_d = StIdle;
                end else if (r_wait_cnt < 3'(WAIT_STATES)) begin
                    w_wait_cnt_d = r_wait_cnt + 3'd1;
                end else begin
                    w_done    = 1'b1;
                    w_state_d = w_start ? StSetup : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Decode works on the transfer captured at SETUP, so the bus may already carry the
    // next SETUP during the completing cycle.
    assign w_err      = (r_addr[1:0] != 2'b00) || (r_addr > ADDR_W'(8));
    assign w_sel_tcr  = (r_addr == ADDR_W'(0));
    assign w_sel_tdr0 = (r_addr == ADDR_W'(4));
    assign w_sel_tdr1 = (r_addr == ADDR_W'(8));
    assign pready     = w_done & ~sys_rst;

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        wr_sel  = 2'b00;
        wdt     = '0;
        wr_strb = '0;
        if (pready) begin
            pslverr = w_err;
            if (r_write) begin
                if (w_sel_tdr0 || w_sel_tdr1) begin
                    wr_sel  = w_sel_tdr0 ? 2'b01 : 2'b10;
                    wdt     = r_wdata;
                    wr_strb = r_strb;
                end
            end else if (w_sel_tcr) begin
                prdata = r_tcr;
            end else if (w_sel_tdr0) begin
                prdata = cnt[31:0];
            end else if (w_sel_tdr1) begin
                prdata = w_tdr1_rd;
            end
        end
    end

    always_comb begin
        w_tcr_d = r_tcr;
        if (pready && r_write && w_sel_tcr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) w_tcr_d[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    assign timer_en = r_tcr[0];
    assign div_val  = r_tcr[11:8];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
            r_tcr      <= TCR_DEFAULT;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_tcr      <= w_tcr_d;
            if (w_state_d == StSetup) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
        end
    end

`ifdef APB_SNAPSHOT_EN
    logic [31:0] r_shadow, w_shadow_d;

    // Shadow mirrors what the counter's high word becomes after a TDR1 write.
    always_comb begin
        w_shadow_d = r_shadow;
        if (pready && !r_write && w_sel_tdr0) begin
            w_shadow_d = cnt[63:32];
        end else if (pready && r_write && w_sel_tdr1) begin
            w_shadow_d = cnt[63:32];
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) w_shadow_d[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_shadow <= '0;
        else         r_shadow <= w_shadow_d;
    end

    assign w_tdr1_rd = r_shadow;
`else
    assign w_tdr1_rd = cnt[63:32];
`endif

endmodule

// File: tb/tb_apb_timer_if.sv
// Self-checking bench for apb_timer_if: transfer-level model checked every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_apb_timer_if;

    localparam int unsigned  WS_A      = 1;
    localparam logic [31:0]  TCR_DEF_A = 32'h0000_0A01;
    localparam logic [31:0]  TCR_DEF_B = 32'h1234_0300;
`ifdef APB_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif
    localparam logic [11:0] B_ADDR [3] = '{12'h004, 12'h008, 12'h000};
    localparam logic [31:0] B_EXP  [3] = '{32'h0246_8ACE, 32'h89AB_CDEF, TCR_DEF_B};

    logic        clk = 1'b0;
    logic        rst, psel, psel_b, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [63:0] cnt;

    logic        pready_a, pslverr_a, timer_en_a, pready_b, pslverr_b, timer_en_b;
    logic [31:0] prdata_a, wdt_a, prdata_b, wdt_b;
    logic [1:0]  wr_sel_a, wr_sel_b;
    logic [3:0]  wr_strb_a, div_val_a, wr_strb_b, div_val_b;

    always #5 clk = ~clk;

    apb_timer_if #(.WAIT_STATES(WS_A), .ADDR_W(12), .TCR_DEFAULT(TCR_DEF_A)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a), .prdata(prdata_a),
        .pslverr(pslverr_a), .wr_sel(wr_sel_a), .wdt(wdt_a), .wr_strb(wr_strb_a),
        .timer_en(timer_en_a), .div_val(div_val_a), .cnt(cnt)
    );

    apb_timer_if #(.WAIT_STATES(0), .ADDR_W(12), .TCR_DEFAULT(TCR_DEF_B)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_b), .prdata(prdata_b),
        .pslverr(pslverr_b), .wr_sel(wr_sel_b), .wdt(wdt_b), .wr_strb(wr_strb_b),
        .timer_en(timer_en_b), .div_val(div_val_b), .cnt(cnt)
    );

    int n_pass, n_fail;

    // Model state and per-cycle expectations for dut_a
    logic [31:0] m_tcr, m_shadow;
    logic        chk_a;
    logic        e_pready, e_pslverr, e_timer_en;
    logic [31:0] e_prdata, e_wdt;
    logic [1:0]  e_wr_sel;
    logic [3:0]  e_wr_strb, e_div_val;

    // Outputs captured on the completing cycle of the last xfer
    logic        c_pready, c_pslverr;
    logic [31:0] c_prdata, c_wdt;
    logic [1:0]  c_wr_sel;
    logic [3:0]  c_wr_strb;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic bit addr_bad(input logic [11:0] a);
        return (a % 4 != 0) || (a > 12'h8);
    endfunction

    task automatic set_idle_exp();
        e_pready = 1'b0; e_pslverr = 1'b0; e_prdata = '0;
        e_wr_sel = 2'b00; e_wdt = '0; e_wr_strb = '0;
        e_timer_en = m_tcr[0];
        e_div_val  = m_tcr[11:8];
    endtask

    task automatic expect_completion(input logic wr, input logic [11:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
        e_pready  = 1'b1;
        e_pslverr = addr_bad(a);
        if (!addr_bad(a)) begin
            if (wr && a != 12'h0) begin
                e_wr_sel  = (a == 12'h4) ? 2'b01 : 2'b10;
                e_wdt     = d;
                e_wr_strb = s;
            end else if (!wr) begin
                case (a)
                    12'h0:   e_prdata = m_tcr;
                    12'h4:   e_prdata = cnt[31:0];
                    default: e_prdata = SNAP ? m_shadow : cnt[63:32];
                endcase
            end
        end
    endtask

    task automatic commit(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        if (!addr_bad(a)) begin
            if (wr && a == 12'h0) m_tcr = merge(m_tcr, d, s);
            if (!wr && a == 12'h4) m_shadow = cnt[63:32];
            if (wr && a == 12'h8) m_shadow = merge(cnt[63:32], d, s);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Standard APB transfer; the model says completion lands 2+WS cycles after SETUP.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        set_idle_exp();
        step();
        penable = 1'b1;
        for (int k = 1; k <= int'(WS_A) + 2; k++) begin
            set_idle_exp();
            if (k == int'(WS_A) + 2) expect_completion(wr, a, d, s);
            @(negedge clk);
            if (k == int'(WS_A) + 2) begin
                c_pready = pready_a; c_pslverr = pslverr_a; c_prdata = prdata_a;
                c_wdt = wdt_a; c_wr_sel = wr_sel_a; c_wr_strb = wr_strb_a;
            end
            step();
            if (k == int'(WS_A) + 2) commit(wr, a, d, s);
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        set_idle_exp();
    endtask

    always @(negedge clk) begin
        if (chk_a) begin
            check("cyc_pready",   64'(pready_a),   64'(e_pready));
            check("cyc_pslverr",  64'(pslverr_a),  64'(e_pslverr));
            check("cyc_prdata",   64'(prdata_a),   64'(e_prdata));
            check("cyc_wr_sel",   64'(wr_sel_a),   64'(e_wr_sel));
            check("cyc_wdt",      64'(wdt_a),      64'(e_wdt));
            check("cyc_wr_strb",  64'(wr_strb_a),  64'(e_wr_strb));
            check("cyc_timer_en", 64'(timer_en_a), 64'(e_timer_en));
            check("cyc_div_val",  64'(div_val_a),  64'(e_div_val));
        end
    end

    initial begin
        int n_rdy;
        n_pass = 0; n_fail = 0; chk_a = 1'b0;
        rst = 1'b1; psel = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; cnt = 64'h0000_0003_1234_5678;
        m_tcr = TCR_DEF_A; m_shadow = '0;
        set_idle_exp();
        repeat (3) step();
        rst = 1'b0; chk_a = 1'b1;
        @(negedge clk);
        check("rst_timer_en", 64'(timer_en_a), 64'h1);
        check("rst_div_val",  64'(div_val_a),  64'hA);
        check("rst_pready",   64'(pready_a),   64'h0);
        check("rst_wr_sel",   64'(wr_sel_a),   64'h0);
        step();

        xfer(1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF);
        check("t1_pready", 64'(c_pready), 64'h1);
        check("t1_wr_sel", 64'(c_wr_sel), 64'h1);
        check("t1_wdt",    64'(c_wdt),    64'hDEAD_BEEF);

        xfer(1'b1, 12'h008, 32'h0000_AB00, 4'b0010);
        check("t2_wr_sel",  64'(c_wr_sel),  64'h2);
        check("t2_wr_strb", 64'(c_wr_strb), 64'h2);
        check("t2_wdt",     64'(c_wdt),     64'h0000_AB00);

        xfer(1'b1, 12'h004, 32'h1111_2222, 4'h0);
        check("strb0_wr_sel",  64'(c_wr_sel),  64'h1);
        check("strb0_wr_strb", 64'(c_wr_strb), 64'h0);

        xfer(1'b1, 12'h000, 32'h0000_0501, 4'hF);
        check("t3_timer_en", 64'(timer_en_a), 64'h1);
        check("t3_div_val",  64'(div_val_a),  64'h5);
        xfer(1'b0, 12'h000, 32'h0, 4'h0);
        check("t3_read_tcr", 64'(c_prdata), 64'h0000_0501);
        xfer(1'b1, 12'h000, 32'hFFFF_0700, 4'b0010);
        xfer(1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0);
        xfer(1'b0, 12'h000, 32'h0, 4'h0);
        check("tcr_partial", 64'(c_prdata), 64'h0000_0701);

        xfer(1'b0, 12'h00C, 32'h0, 4'h0);
        check("t4_0c_err",    64'(c_pslverr), 64'h1);
        check("t4_0c_prdata", 64'(c_prdata),  64'h0);
        xfer(1'b0, 12'h006, 32'h0, 4'h0);
        check("t4_06_err",    64'(c_pslverr), 64'h1);
        check("t4_06_prdata", 64'(c_prdata),  64'h0);
        xfer(1'b1, 12'h005, 32'hAAAA_AAAA, 4'hF);
        check("t4_05_wr_sel", 64'(c_wr_sel), 64'h0);
        xfer(1'b1, 12'h001, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b0, 12'h000, 32'h0, 4'h0);
        check("t4_tcr_kept", 64'(c_prdata), 64'h0000_0701);

        cnt = 64'h0000_0001_FFFF_FFFF;
        xfer(1'b0, 12'h004, 32'h0, 4'h0);
        check("t5_tdr0", 64'(c_prdata), 64'hFFFF_FFFF);
        cnt = 64'h0000_0002_0000_0000;
        xfer(1'b0, 12'h008, 32'h0, 4'h0);
        check("t5_tdr1", 64'(c_prdata), SNAP ? 64'h1 : 64'h2);

        // Protocol violation: psel dropped while the FSM is in SETUP
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
        set_idle_exp();
        step();
        psel = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pready_a) n_rdy++;
            step();
        end
        check("t7_drop_psel", 64'(n_rdy), 64'h0);

        // WAIT_STATES=0: next SETUP is presented in the completing cycle
        cnt = 64'h89AB_CDEF_0246_8ACE;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = B_ADDR[0];
        step();
        for (int i = 0; i < 3; i++) begin
            penable = 1'b1;
            @(negedge clk);
            check("t7_b2b_gap", 64'(pready_b), 64'h0);
            step();
            if (i < 2) begin
                penable = 1'b0;
                paddr   = B_ADDR[i+1];
            end
            @(negedge clk);
            check("t7_b2b_rdy",    64'(pready_b), 64'h1);
            check("t7_b2b_prdata", 64'(prdata_b), 64'(B_EXP[i]));
            step();
        end
        psel_b = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("t7_b2b_end", 64'(pready_b), 64'h0);
        step();

        // Reset during ACCESS of a TDR0 write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        set_idle_exp();
        step();
        penable = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t6_wr_sel_a", 64'(wr_sel_a), 64'h0);
        step();
        m_tcr = TCR_DEF_A; m_shadow = '0;
        set_idle_exp();
        @(negedge clk);
        check("t6_pready",   64'(pready_a),   64'h0);
        check("t6_wr_sel_b", 64'(wr_sel_a),   64'h0);
        check("t6_timer_en", 64'(timer_en_a), 64'h1);
        check("t6_div_val",  64'(div_val_a),  64'hA);
        step();
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        step();
        xfer(1'b0, 12'h000, 32'h0, 4'h0);
        check("t6_tcr_default", 64'(c_prdata), 64'h0000_0A01);
        step();

        chk_a = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
